distance_avg_filter: RTL and testbench

//  Downstream of the ADC-to-distance LUT stage.

---
 rtl/dist_filt_pkg.sv | 18 +
 rtl/distance_avg_filter_sample_tick_gen.sv | 27 ++
 rtl/distance_avg_filter.sv | 116 +++++++++++
 tb/tb_distance_avg_filter.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/dist_filt_pkg.sv
// Shared types for the distance boxcar filter: sample width, FSM encoding and a
// small unsigned absolute-difference helper.
package dist_filt_pkg;

  localparam int DIST_W = 7;

  typedef logic [DIST_W-1:0] dist_cm_t;

  typedef enum logic {
    FILL,
    RUN
  } filt_state_t;

  function automatic dist_cm_t abs_diff(input dist_cm_t a, input dist_cm_t b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/distance_avg_filter_sample_tick_gen.sv
// Decimating prescaler: one sample_tick every SAMPLE_DIV enabled clocks.
// enable=0 freezes the count and masks the tick.
module sample_tick_gen #(
  parameter int SAMPLE_DIV = 125000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic sample_tick
);

  localparam int CNT_W = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SAMPLE_DIV - 1);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
    end else if (enable) begin
      count_reg <= (count_reg == LAST) ? '0 : count_reg + CNT_W'(1);
    end
  end

  assign sample_tick = enable && (count_reg == LAST);

endmodule

// File: rtl/distance_avg_filter.sv
// DEPTH-point boxcar average of the decimated distance_cm_in stream, with a
// FILL->RUN window-full flag. Optional outlier clamp: DIST_OUTLIER_REJECT_EN.
module distance_avg_filter
  import dist_filt_pkg::*;
#(
  parameter int DEPTH_LOG2 = 3,
  parameter int SAMPLE_DIV = 125000,
  parameter int MAX_STEP   = 10
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     enable,
  input  dist_cm_t distance_cm_in,
  output logic     sample_tick,
  output dist_cm_t distance_cm_out,
  output logic     out_valid
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int SUM_W = DIST_W + DEPTH_LOG2;

  if (SAMPLE_DIV < 2) begin : g_bad_div
    $error("SAMPLE_DIV must be >= 2");
  end
  if (DEPTH_LOG2 < 1) begin : g_bad_depth
    $error("DEPTH_LOG2 must be >= 1");
  end
  if (MAX_STEP < 0 || MAX_STEP >= (1 << DIST_W)) begin : g_bad_step
    $error("MAX_STEP out of range");
  end

  dist_cm_t                ring [DEPTH];
  dist_cm_t                oldest_reg;
  logic [DEPTH_LOG2-1:0]   wr_ptr_reg;
  logic [DEPTH_LOG2-1:0]   fill_cnt_reg;
  logic [SUM_W-1:0]        sum_reg;
  logic [SUM_W-1:0]        sum_next;
  filt_state_t             state_reg;
  logic                    upd_reg;
  dist_cm_t                sample_next;
  dist_cm_t                oldest_eff;

  sample_tick_gen #(
    .SAMPLE_DIV(SAMPLE_DIV)
  ) u_tick (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .sample_tick(sample_tick)
  );

`ifdef DIST_OUTLIER_REJECT_EN
  localparam dist_cm_t MAX_STEP_CM = dist_cm_t'(MAX_STEP);

  always_comb begin
    sample_next = distance_cm_in;
    if (state_reg == RUN && abs_diff(distance_cm_in, distance_cm_out) > MAX_STEP_CM) begin
      sample_next = distance_cm_out;
    end
  end
`else
  always_comb begin
    sample_next = distance_cm_in;
  end
`endif

  // Ring contents are never reset: while filling, every slot is written before
  // it is ever retired, so treating the retired value as zero is equivalent.
  always_comb begin
    oldest_eff = (state_reg == FILL) ? '0 : oldest_reg;
    sum_next   = sum_reg + SUM_W'(sample_next) - SUM_W'(oldest_eff);
  end

  // Registered read of the slot about to be overwritten. wr_ptr only moves on a
  // tick and ticks are at least two clocks apart, so this is always current.
  always_ff @(posedge clk) begin
    if (sample_tick && !reset) begin
      ring[wr_ptr_reg] <= sample_next;
    end
    oldest_reg <= ring[wr_ptr_reg];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg      <= '0;
      fill_cnt_reg    <= '0;
      sum_reg         <= '0;
      state_reg       <= FILL;
      upd_reg         <= 1'b0;
      distance_cm_out <= '0;
      out_valid       <= 1'b0;
    end else begin
      upd_reg <= sample_tick;

      if (sample_tick) begin
        sum_reg    <= sum_next;
        wr_ptr_reg <= wr_ptr_reg + DEPTH_LOG2'(1);
        if (state_reg == FILL) begin
          fill_cnt_reg <= fill_cnt_reg + DEPTH_LOG2'(1);
          if (fill_cnt_reg == DEPTH_LOG2'(DEPTH - 1)) begin
            state_reg <= RUN;
          end
        end
      end

      // One clock after the tick, publish the floored mean of the new window.
      if (upd_reg) begin
        distance_cm_out <= sum_reg[SUM_W-1:DEPTH_LOG2];
        if (state_reg == RUN) begin
          out_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_distance_avg_filter.sv
// Self-checking bench for distance_avg_filter (SAMPLE_DIV=4, DEPTH_LOG2=3, MAX_STEP=10);
// honours DIST_OUTLIER_REJECT_EN in its reference model.
module tb_distance_avg_filter;

  localparam int DIV   = 4;
  localparam int DLOG  = 3;
  localparam int DEPTH = 8;
  localparam int STEP  = 10;
`ifdef DIST_OUTLIER_REJECT_EN
  localparam bit OUTLIER = 1'b1;
`else
  localparam bit OUTLIER = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [6:0] din = '0;
  logic       sample_tick;
  logic [6:0] dout;
  logic       out_valid;

  int n_tests = 0;
  int n_fail  = 0;

  distance_avg_filter #(
    .DEPTH_LOG2(DLOG),
    .SAMPLE_DIV(DIV),
    .MAX_STEP  (STEP)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .distance_cm_in (din),
    .sample_tick    (sample_tick),
    .distance_cm_out(dout),
    .out_valid      (out_valid)
  );

  always #4 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: window as a queue of accepted samples, tick from a count
  // of enabled clocks since reset, result visible two cycles after the tick.
  int win[$];
  int en_cnt = 0, ticks = 0, exp_out = 0, pend_val = 0;
  bit exp_valid = 0, pend = 0, pend_valid = 0, exp_tick = 0;
  bit s_r = 1, s_e = 0, s_tick = 0;
  int s_x = 0, s_outref = 0;

  always @(negedge clk) begin
    if (s_r) begin
      en_cnt = 0; ticks = 0; exp_out = 0; exp_valid = 0; pend = 0;
      win.delete();
    end else begin
      if (pend) begin
        pend = 0; exp_out = pend_val; exp_valid = pend_valid;
      end
      if (s_tick) begin
        int x, sum, d;
        x = s_x;
        d = (x > s_outref) ? x - s_outref : s_outref - x;
        if (OUTLIER && ticks >= DEPTH && d > STEP) x = s_outref;
        win.push_back(x);
        if (win.size() > DEPTH) void'(win.pop_front());
        sum = 0;
        foreach (win[k]) sum += win[k];
        ticks++;
        pend = 1; pend_val = sum / DEPTH; pend_valid = (ticks >= DEPTH);
        $display("[TB] tick %0d in=%0d accepted=%0d expect_out=%0d expect_valid=%0d",
                 ticks, s_x, x, pend_val, pend_valid);
      end
      if (s_e) en_cnt++;
    end
    exp_tick = enable && (en_cnt % DIV == DIV - 1);
    if (!reset) check("sample_tick", sample_tick, exp_tick);
    check("distance_cm_out", dout, exp_out);
    check("out_valid", out_valid, exp_valid);
    s_r = reset; s_e = enable; s_x = din;
    s_tick = exp_tick && !reset; s_outref = exp_out;
  end

  task automatic step(input bit r, input bit e, input int x);
    @(posedge clk);
    #1;
    reset = r; enable = e; din = 7'(x);
  endtask

  task automatic run(input int n, input bit e, input int x);
    repeat (n) step(1'b0, e, x);
  endtask

  int cur;

  initial begin
    // 1. fill at 50
    repeat (2) step(1'b1, 1'b1, 50);
    run(28, 1'b1, 50);
    @(negedge clk);
    check("fill_valid_low_early", out_valid, 1'b0);
    run(12, 1'b1, 50);
    @(negedge clk);
    check("fill_out_50", dout, 50);
    check("fill_valid", out_valid, 1'b1);

    // 2. step 50 -> 90
    run(40, 1'b1, 90);
    @(negedge clk);
    check("step_out", dout, OUTLIER ? 50 : 90);

    // 3. full scale then decay to zero
    step(1'b1, 1'b1, 127);
    run(40, 1'b1, 127);
    @(negedge clk);
    check("full_scale_127", dout, 127);
    run(40, 1'b1, 0);
    @(negedge clk);
    check("decay_zero", dout, OUTLIER ? 127 : 0);

    // 4. freeze with enable=0
    step(1'b1, 1'b1, 50);
    run(41, 1'b1, 50);
    run(20, 1'b0, 90);
    @(negedge clk);
    check("freeze_out", dout, 50);
    check("freeze_valid", out_valid, 1'b1);
    run(10, 1'b1, 50);

    // 5. reset mid-window
    run(2, 1'b1, 50);
    step(1'b1, 1'b1, 50);
    step(1'b0, 1'b1, 50);
    @(negedge clk);
    check("reset_out_0", dout, 0);
    check("reset_valid_0", out_valid, 1'b0);
    run(40, 1'b1, 50);

    // 6. single-tick spike
    run(4, 1'b1, 100);
    run(2, 1'b1, 50);
    @(negedge clk);
    check("spike_out", dout, OUTLIER ? 50 : 56);
    run(40, 1'b1, 50);
    @(negedge clk);
    check("spike_recover", dout, 50);

    // 7. randomized: jumps and small walks, random enable, rare resets
    cur = 60;
    for (int i = 0; i < 900; i++) begin
      if ($urandom_range(0, 3) == 0) cur = $urandom_range(0, 127);
      else cur = cur + $urandom_range(0, 24) - 12;
      if (cur < 0) cur = 0;
      if (cur > 127) cur = 127;
      step(($urandom_range(0, 149) == 0), ($urandom_range(0, 9) != 0), cur);
    end
    run(8, 1'b1, cur);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
